// File: rtl/dda_segment_scheduler_if.sv
// Host-side segment handshake: a segment moves on any edge where seg_valid && seg_ready.
// seg_xe/seg_ye are signed relative end points and only mean something while seg_valid is high.
interface dda_segment_scheduler_if;
    logic               seg_valid;
    logic               seg_ready;
    logic signed [31:0] seg_xe;
    logic signed [31:0] seg_ye;

    modport master (output seg_valid, output seg_xe, output seg_ye, input seg_ready);
    modport slave  (input seg_valid, input seg_xe, input seg_ye, output seg_ready);
endinterface

// File: rtl/dda_segment_scheduler.sv
// Queues relative line segments and feeds them one at a time to the DDA interpolator engine.
// Also integrates the engine's step pulses into an absolute X/Y position.
module dda_segment_scheduler #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                        pulse_clk,
    input  logic                        sys_rst_l,
    dda_segment_scheduler_if.slave      seg,
    input  logic                        abort,
    output logic signed [31:0]          eng_xe,
    output logic signed [31:0]          eng_ye,
    output logic                        eng_load,
    output logic                        eng_abort,
    input  logic                        eng_busy,
    input  logic                        x_acc,
    input  logic                        x_dec,
    input  logic                        y_acc,
    input  logic                        y_dec,
    input  logic                        pos_preload,
    input  logic signed [31:0]          pos_preload_x,
    input  logic signed [31:0]          pos_preload_y,
    output logic signed [31:0]          pos_x,
    output logic signed [31:0]          pos_y,
    output logic                        busy,
    output logic                        seg_done,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic [2:0]                  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [3:0]    GAP_LAST   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam logic [1:0]    WAIT_LAST  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_GAPW = 3'd4
    } state_e;

    state_e          state;
    logic [63:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic            push;
    logic            pop;
    logic [63:0]     head;
    logic            head_zero;
    logic [1:0]      wait_cnt;
    logic [3:0]      gap_cnt;
    logic signed [31:0] dx;
    logic signed [31:0] dy;

    // Abort wins over a simultaneous push, so the offered segment is simply lost.
    assign seg.seg_ready = (level != FULL_LEVEL);
    assign push          = seg.seg_valid && seg.seg_ready && !abort;
    assign pop           = (state == S_IDLE) && (level != '0) && !abort;
    assign head          = mem[rd_ptr];
    assign head_zero     = (head == '0);

    assign busy       = (state != S_IDLE) || (level != '0);
    assign fifo_level = level;
    assign state_dbg  = state;

    always_ff @(posedge pulse_clk) begin
        if (push) begin
            mem[wr_ptr] <= {seg.seg_xe, seg.seg_ye};
        end
    end

    always_ff @(posedge pulse_clk) begin
        if (!sys_rst_l || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // eng_load is raised on the pop edge so it is high exactly while the FSM sits in LOAD.
    always_ff @(posedge pulse_clk) begin
        if (!sys_rst_l) begin
            state     <= S_IDLE;
            eng_xe    <= '0;
            eng_ye    <= '0;
            eng_load  <= 1'b0;
            eng_abort <= 1'b0;
            seg_done  <= 1'b0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            eng_load  <= 1'b0;
            eng_abort <= 1'b0;
            seg_done  <= 1'b0;
            if (abort) begin
                eng_abort <= (state == S_LOAD) || (state == S_WAIT) || (state == S_RUN);
                state     <= S_IDLE;
                wait_cnt  <= '0;
                gap_cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (level != '0) begin
                            eng_xe <= head[63:32];
                            eng_ye <= head[31:0];
                            if (head_zero) begin
                                seg_done <= 1'b1;
                            end else begin
                                eng_load <= 1'b1;
                                state    <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (eng_busy) begin
                            state <= S_RUN;
                        end else if (wait_cnt == WAIT_LAST) begin
                            // Engine never went busy: it finished the move on its own.
                            seg_done <= 1'b1;
                            gap_cnt  <= '0;
                            state    <= (GAP == 0) ? S_IDLE : S_GAPW;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!eng_busy) begin
                            seg_done <= 1'b1;
                            gap_cnt  <= '0;
                            state    <= (GAP == 0) ? S_IDLE : S_GAPW;
                        end
                    end
                    S_GAPW: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dx = '0;
        dy = '0;
        if (x_acc && !x_dec)      dx = 32'sd1;
        else if (x_dec && !x_acc) dx = -32'sd1;
        if (y_acc && !y_dec)      dy = 32'sd1;
        else if (y_dec && !y_acc) dy = -32'sd1;
    end

    always_ff @(posedge pulse_clk) begin
        if (!sys_rst_l) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (pos_preload) begin
            pos_x <= pos_preload_x;
            pos_y <= pos_preload_y;
        end else begin
            pos_x <= pos_x + dx;
            pos_y <= pos_y + dy;
        end
    end

endmodule

// File: tb/tb_dda_segment_scheduler.sv
// Directed bench for dda_segment_scheduler: a small engine model answers eng_load with eng_busy,
// a scoreboard queue holds the expected {cycle, xe, ye} of every engine load.
module tb_dda_segment_scheduler;

  logic pulse_clk = 1'b0;
  logic sys_rst_l = 1'b0;
  always #5 pulse_clk = ~pulse_clk;

  dda_segment_scheduler_if sif ();

  logic               abort;
  logic signed [31:0] eng_xe, eng_ye;
  logic               eng_load, eng_abort, eng_busy;
  logic               x_acc, x_dec, y_acc, y_dec;
  logic               pos_preload;
  logic signed [31:0] pos_preload_x, pos_preload_y;
  logic signed [31:0] pos_x, pos_y;
  logic               busy, seg_done;
  logic [2:0]         fifo_level;
  logic [2:0]         state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int last_done_cyc = 0;
  int busy_len = 0;
  int eng_cnt = 0;
  int c = 0;
  logic [95:0] exp_q[$];
  logic [95:0] exp_v;

  dda_segment_scheduler #(.DEPTH(4), .GAP(2)) u_dut (
    .pulse_clk     (pulse_clk),
    .sys_rst_l     (sys_rst_l),
    .seg           (sif.slave),
    .abort         (abort),
    .eng_xe        (eng_xe),
    .eng_ye        (eng_ye),
    .eng_load      (eng_load),
    .eng_abort     (eng_abort),
    .eng_busy      (eng_busy),
    .x_acc         (x_acc),
    .x_dec         (x_dec),
    .y_acc         (y_acc),
    .y_dec         (y_dec),
    .pos_preload   (pos_preload),
    .pos_preload_x (pos_preload_x),
    .pos_preload_y (pos_preload_y),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .busy          (busy),
    .seg_done      (seg_done),
    .fifo_level    (fifo_level),
    .state_dbg     (state_dbg)
  );

  always @(posedge pulse_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] pk(input int cy, input int xe, input int ye);
    return {cy, xe, ye};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge pulse_clk);
    #1;
  endtask

  task automatic drive_seg(input int xe, input int ye);
    sif.seg_valid = 1'b1;
    sif.seg_xe    = xe;
    sif.seg_ye    = ye;
    tick(1);
    sif.seg_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic check_reset(input string tag);
    @(negedge pulse_clk);
    check({tag, "_ready"}, sif.seg_ready, 1'b1);
    check({tag, "_flags"}, {eng_load, eng_abort, busy, seg_done, fifo_level, state_dbg}, '0);
    check({tag, "_pos"}, {pos_x, pos_y}, '0);
    check({tag, "_eng"}, {eng_xe, eng_ye}, '0);
  endtask

  // Engine model: eng_busy rises in the load cycle and stays high busy_len cycles.
  initial begin
    eng_busy = 1'b0;
    forever begin
      @(posedge pulse_clk);
      #1;
      if (!sys_rst_l || eng_abort) eng_cnt = 0;
      else if (eng_load)           eng_cnt = busy_len;
      else if (eng_cnt != 0)       eng_cnt--;
      eng_busy = (eng_cnt != 0);
    end
  end

  always @(negedge pulse_clk) begin
    if (sys_rst_l) begin
      if (eng_load) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL load_unexpected actual xe=%0d ye=%0d cyc=%0d required=no load",
                   eng_xe, eng_ye, cyc);
        end else begin
          exp_v = exp_q.pop_front();
          check("load", pk(cyc, eng_xe, eng_ye), exp_v);
        end
      end
      if (seg_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (eng_abort) abort_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    sif.seg_valid = 1'b0;
    sif.seg_xe = '0;
    sif.seg_ye = '0;
    abort = 1'b0;
    {x_acc, x_dec, y_acc, y_dec} = '0;
    pos_preload = 1'b0;
    pos_preload_x = '0;
    pos_preload_y = '0;

    check_reset("rst");
    tick(1);
    sys_rst_l = 1'b1;
    tick(2);

    // 1: single segment, engine busy for 100 cycles
    busy_len = 100;
    c = cyc;
    exp_q.push_back(pk(c + 2, 100, -40));
    drive_seg(100, -40);
    wait_done(1, 150, "t1_done_cnt");
    check("t1_done_cyc", last_done_cyc, c + 103);
    tick(6);

    // 2: one running segment plus four queued; the sixth offer hits a full FIFO
    busy_len = 6;
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pk(c + 2 + 10 * i, 10 + i, -(20 + i)));
      drive_seg(10 + i, -(20 + i));
    end
    @(negedge pulse_clk);
    check("t2_full_ready", sif.seg_ready, 1'b0);
    check("t2_full_level", fifo_level, 3'd4);
    tick(1);
    drive_seg(999, 999);
    @(negedge pulse_clk);
    check("t2_ignored_level", fifo_level, 3'd4);
    wait_done(6, 100, "t2_done_cnt");
    tick(10);
    check("t2_done_stable", done_cnt, 6);

    // 3: zero-length segment completes without touching the engine
    busy_len = 4;
    c = cyc;
    exp_q.push_back(pk(c + 3, 5, 5));
    drive_seg(0, 0);
    drive_seg(5, 5);
    @(negedge pulse_clk);
    check("t3_zero_drop", {seg_done, eng_load}, 2'b10);
    wait_done(8, 40, "t3_done_cnt");
    tick(8);

    // 4: position integration and wrap-around
    x_acc = 1'b1; tick(10);
    @(negedge pulse_clk);
    check("t4_acc10", pos_x, 32'sd10);
    tick(0);
    x_acc = 1'b0; x_dec = 1'b1; tick(3);
    x_acc = 1'b1; tick(1);
    x_acc = 1'b0; x_dec = 1'b0; y_dec = 1'b1; tick(7);
    y_dec = 1'b0;
    @(negedge pulse_clk);
    check("t4_pos", {pos_x, pos_y}, {32'sd7, -32'sd7});
    tick(0);
    pos_preload = 1'b1;
    pos_preload_x = 32'h7FFF_FFFF;
    pos_preload_y = 32'h8000_0000;
    tick(1);
    pos_preload = 1'b0;
    x_acc = 1'b1; y_dec = 1'b1; tick(1);
    x_acc = 1'b0; y_dec = 1'b0;
    @(negedge pulse_clk);
    check("t4_wrap", {pos_x, pos_y}, {32'h8000_0000, 32'h7FFF_FFFF});
    tick(2);

    // 5: abort while running with two segments queued
    busy_len = 30;
    c = cyc;
    exp_q.push_back(pk(c + 2, 1, 2));
    drive_seg(1, 2);
    drive_seg(3, 4);
    drive_seg(5, 6);
    tick(1);
    @(negedge pulse_clk);
    check("t5_pre_state", {state_dbg, fifo_level}, {3'd3, 3'd2});
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge pulse_clk);
    check("t5_abort", {eng_abort, fifo_level, state_dbg, busy}, {1'b1, 3'd0, 3'd0, 1'b0});
    tick(40);
    check("t5_no_done", done_cnt, 8);
    check("t5_abort_cnt", abort_cnt, 1);

    // 6: reset mid-move drops everything
    c = cyc;
    exp_q.push_back(pk(c + 2, -7, 9));
    drive_seg(-7, 9);
    drive_seg(11, 12);
    tick(2);
    @(negedge pulse_clk);
    check("t6_pre_state", state_dbg, 3'd3);
    tick(0);
    sys_rst_l = 1'b0;
    tick(1);
    check_reset("t6");
    tick(0);
    sys_rst_l = 1'b1;
    tick(15);
    check("t6_abort_cnt", abort_cnt, 1);
    check("t6_done_cnt", done_cnt, 8);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
